// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scan, debounce and hex encode; define KEYPAD_REPEAT_EN for auto-repeat while a key is held
module keypad_scanner #(
    parameter int SCAN_DIV      = 4,
    parameter int DEBOUNCE_CNT  = 8,
    parameter int REPEAT_PERIOD = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);
    // nibble index is {row, col}: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = E 0 F D
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    state_t        state;
    logic [3:0]    rs_meta, rs;
    logic [1:0]    col_idx, row_idx;
    logic [DW-1:0] div;
    logic [CW-1:0] cnt;
`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_PERIOD + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_PERIOD - 1);
    logic [RW-1:0] rep;
`endif

    logic       rs_one_hot, row_bit;
    logic [1:0] rs_row_idx, next_col;
    logic [3:0] next_onehot;

    assign rs_one_hot  = (rs != 4'd0) && ((rs & (rs - 4'd1)) == 4'd0);
    assign rs_row_idx  = rs[3] ? 2'd3 : rs[2] ? 2'd2 : rs[1] ? 2'd1 : 2'd0;
    assign row_bit     = rs[row_idx];
    assign next_col    = col_idx + 2'd1;
    assign next_onehot = 4'b0001 << next_col;

    // two-flop synchronizer for the asynchronous row lines
    always_ff @(posedge clk) begin
        if (!rst) {rs, rs_meta} <= '0;
        else      {rs, rs_meta} <= {rs_meta, row_in};
    end

    // scan / debounce / hold / release state machine with registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= SCAN;
            col_idx   <= '0;
            row_idx   <= '0;
            div       <= '0;
            cnt       <= '0;
            col_out   <= 4'b0001;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep       <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (div != DIV_LAST) div <= div + DW'(1);
                    else if (rs_one_hot) begin
                        row_idx <= rs_row_idx;
                        cnt     <= '0;
                        state   <= DEBOUNCE;
                    end else begin
                        col_idx <= next_col;
                        col_out <= next_onehot;
                        div     <= '0;
                    end
                end
                DEBOUNCE: begin
                    if (rs != (4'b0001 << row_idx)) begin
                        col_idx <= next_col;
                        col_out <= next_onehot;
                        div     <= '0;
                        state   <= SCAN;
                    end else if (cnt == CNT_LAST) begin
                        key_code  <= KEY_MAP[{row_idx, col_idx, 2'b00} +: 4];
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        state     <= HOLD;
`ifdef KEYPAD_REPEAT_EN
                        rep       <= '0;
`endif
                    end else cnt <= cnt + CW'(1);
                end
                HOLD: begin
                    if (!row_bit) begin
                        cnt   <= '0;
                        state <= RELEASE;
`ifdef KEYPAD_REPEAT_EN
                        rep   <= '0;
                    end else if (rep == REP_LAST) begin
                        rep       <= '0;
                        key_valid <= 1'b1;
                    end else begin
                        rep <= rep + RW'(1);
`endif
                    end
                end
                RELEASE: begin
                    if (row_bit) cnt <= '0;
                    else if (cnt == CNT_LAST) begin
                        key_held <= 1'b0;
                        col_idx  <= next_col;
                        col_out  <= next_onehot;
                        div      <= '0;
                        state    <= SCAN;
                    end else cnt <= cnt + CW'(1);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized keypad presses against a behavioural keypad/timing model
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DC = 8;
    localparam int RP = 16;
    localparam int LAT_MIN = DC + 3;
    localparam int LAT_MAX = 4 * SD + DC + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out, key_code;
    logic       key_valid, key_held;

    logic [15:0] keys = '0;
    logic        force_en = 1'b0;
    logic [3:0]  force_val = '0;
    logic [3:0]  kmap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                 '{4'h4, 4'h5, 4'h6, 4'hB},
                                 '{4'h7, 4'h8, 4'h9, 4'hC},
                                 '{4'hE, 4'h0, 4'hF, 4'hD}};

    int checks = 0, failures = 0;
    int cyc = 0, strobes = 0, last_t = 0;
    logic [3:0] last_code = '0;
    logic prev_kv = 1'b0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // physical matrix: a pressed key ties its column drive onto its row line
    always_comb begin
        row_in = '0;
        for (int r = 0; r < 4; r++) row_in[r] = |(keys[r*4 +: 4] & col_out);
        if (force_en) row_in = force_val;
    end

    // a strobe must never be followed directly by another strobe
    always @(negedge clk) begin
        if (key_valid) begin
            checks++;
            if (prev_kv) begin
                failures++;
                $display("FAIL strobe_back_to_back at cycle %0d: key_valid high two cycles in a row", cyc);
            end
        end
        prev_kv = key_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        cyc++;
        if (key_valid) begin
            strobes++;
            last_code = key_code;
            last_t = cyc;
        end
    endtask

    task automatic release_keys(output int fall);
        int t0;
        t0 = cyc;
        keys = '0;
        fall = -1;
        for (int i = 0; i < DC + 20 && fall < 0; i++) begin
            step();
            if (!key_held) fall = cyc - t0;
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        rst = 1'b0; force_en = 1'b1; force_val = 4'b1111;
        repeat (5) step();
        checks++; if (col_out !== 4'b0001) begin failures++; $display("FAIL reset_col got=%b want=0001", col_out); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", key_valid); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL reset_held got=%b want=0", key_held); end
        checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL reset_code got=%h want=0", key_code); end
        rst = 1'b1; force_en = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            exp = 4'b0001 << ((i / SD) % 4);
            checks++;
            if (col_out !== exp) begin failures++; $display("FAIL scan_rotate step %0d got=%b want=%b", i, col_out, exp); end
        end
    endtask

    task automatic test_press(input int r, input int c, input int extra);
        int t0, s0, lat, fall;
        s0 = strobes; t0 = cyc; lat = -1;
        keys[r*4+c] = 1'b1;
        for (int i = 0; i < LAT_MAX + 8 && lat < 0; i++) begin
            step();
            if (strobes != s0) lat = cyc - t0;
        end
        checks++; if (lat < LAT_MIN || lat > LAT_MAX) begin failures++; $display("FAIL press_latency key r%0d c%0d got=%0d want=%0d..%0d", r, c, lat, LAT_MIN, LAT_MAX); end
        repeat (extra) step();
        checks++; if (strobes - s0 != 1) begin failures++; $display("FAIL press_count key r%0d c%0d got=%0d want=1", r, c, strobes - s0); end
        checks++; if (last_code !== kmap[r][c]) begin failures++; $display("FAIL press_code got=%h want=%h", last_code, kmap[r][c]); end
        checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL press_held got=%b want=1", key_held); end
        s0 = strobes;
        release_keys(fall);
        checks++; if (fall < DC || fall > DC + 4) begin failures++; $display("FAIL release_time got=%0d want=%0d..%0d", fall, DC, DC + 4); end
        checks++; if (col_out !== 4'(4'b0001 << ((c + 1) % 4))) begin failures++; $display("FAIL release_next_col got=%b want col %0d", col_out, (c + 1) % 4); end
        checks++; if (strobes != s0) begin failures++; $display("FAIL release_strobe got=%0d want=0", strobes - s0); end
    endtask

    task automatic test_bounce();
        int s0, t0, lat, fall;
        s0 = strobes;
        for (int i = 0; i < 20; i++) begin
            keys[15] = ((i / 3) % 2) == 0;
            step();
        end
        checks++; if (strobes != s0) begin failures++; $display("FAIL bounce_quiet got=%0d want=0", strobes - s0); end
        keys[15] = 1'b1; t0 = cyc; lat = -1;
        for (int i = 0; i < LAT_MAX + 8 && lat < 0; i++) begin
            step();
            if (strobes != s0) lat = cyc - t0;
        end
        checks++; if (lat < 0 || lat > LAT_MAX) begin failures++; $display("FAIL bounce_latency got=%0d want<=%0d", lat, LAT_MAX); end
        repeat (6) step();
        checks++; if (strobes - s0 != 1) begin failures++; $display("FAIL bounce_count got=%0d want=1", strobes - s0); end
        checks++; if (last_code !== 4'hD) begin failures++; $display("FAIL bounce_code got=%h want=d", last_code); end
        release_keys(fall);
        checks++; if (fall < 0) begin failures++; $display("FAIL bounce_release got=timeout want=fall"); end
    endtask

    task automatic test_ghost();
        int s0, fall;
        s0 = strobes;
        keys[0] = 1'b1; keys[8] = 1'b1;
        repeat (60) step();
        checks++; if (strobes != s0) begin failures++; $display("FAIL ghost_strobe got=%0d want=0", strobes - s0); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL ghost_held got=%b want=0", key_held); end
        release_keys(fall);
    endtask

    task automatic test_single_press();
        int s0, fall;
        s0 = strobes;
        keys[0] = 1'b1;
        for (int i = 0; i < LAT_MAX + 8 && strobes == s0; i++) step();
        checks++; if (strobes - s0 != 1 || last_code !== 4'h1) begin failures++; $display("FAIL single_first got=%0d/%h want=1/1", strobes - s0, last_code); end
        s0 = strobes;
        keys[14] = 1'b1;
        repeat (10) step();
        checks++; if (strobes != s0 || key_held !== 1'b1) begin failures++; $display("FAIL single_second_held strobes=%0d held=%b want=0/1", strobes - s0, key_held); end
        keys[0] = 1'b0; fall = -1;
        for (int i = 0; i < DC + 20 && fall < 0; i++) begin
            step();
            if (!key_held) fall = i;
        end
        checks++; if (fall < 0 || strobes != s0) begin failures++; $display("FAIL single_release fall=%0d strobes=%0d want fall and 0", fall, strobes - s0); end
        for (int i = 0; i < LAT_MAX + 8 && strobes == s0; i++) step();
        checks++; if (strobes - s0 != 1 || last_code !== 4'hF) begin failures++; $display("FAIL single_followup got=%0d/%h want=1/f", strobes - s0, last_code); end
        release_keys(fall);
    endtask

    task automatic test_reset_mid_press();
        int s0, run;
        s0 = strobes; run = 0;
        keys[10] = 1'b1;
        for (int i = 0; i < 80 && run < SD + 2; i++) begin
            step();
            run = (col_out == 4'b0100) ? run + 1 : 0;
        end
        checks++; if (run < SD + 2) begin failures++; $display("FAIL midreset_debounce got=timeout want=column held"); end
        rst = 1'b0;
        step();
        checks++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin failures++; $display("FAIL midreset_outputs got=%b/%b want=0/0", key_valid, key_held); end
        checks++; if (col_out !== 4'b0001) begin failures++; $display("FAIL midreset_col got=%b want=0001", col_out); end
        checks++; if (strobes != s0 || key_code !== 4'h0) begin failures++; $display("FAIL midreset_code strobes=%0d code=%h want=0/0", strobes - s0, key_code); end
        keys = '0;
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_repeat();
        int s0, tp, fall, exp_rep;
`ifdef KEYPAD_REPEAT_EN
        exp_rep = 60 / RP;
`else
        exp_rep = 0;
`endif
        s0 = strobes;
        keys[13] = 1'b1;
        for (int i = 0; i < LAT_MAX + 8 && strobes == s0; i++) step();
        checks++; if (strobes - s0 != 1 || last_code !== 4'h0) begin failures++; $display("FAIL repeat_first got=%0d/%h want=1/0", strobes - s0, last_code); end
        s0 = strobes; tp = last_t;
        for (int i = 0; i < 60; i++) begin
            step();
            if (last_t != tp) begin
                checks++; if (last_t - tp != RP || last_code !== 4'h0) begin failures++; $display("FAIL repeat_spacing got=%0d/%h want=%0d/0", last_t - tp, last_code, RP); end
                tp = last_t;
            end
        end
        checks++; if (strobes - s0 != exp_rep) begin failures++; $display("FAIL repeat_count got=%0d want=%0d", strobes - s0, exp_rep); end
        release_keys(fall);
    endtask

    initial begin
        int r, c;
        test_reset();
        test_press(1, 1, 13);
        for (int k = 0; k < 6; k++) begin
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            repeat ($urandom_range(0, 15)) step();
            test_press(r, c, int'($urandom_range(2, 12)));
        end
        test_bounce();
        test_ghost();
        test_single_press();
        test_reset_mid_press();
        test_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
